// File: rtl/servo_pwm_gen_if.sv
// Control/status bundle between the PWM generator and its register front end.
// master drives the configuration; slave is the generator itself.
interface servo_pwm_gen_if #(
  parameter int CNT_W = 28
) ();
  logic             enable;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_load;
  logic             pwm_out;
  logic             period_start;
  logic             cfg_pending;
  logic             failsafe;
  logic [CNT_W-1:0] active_duty;

  modport master (
    output enable, cfg_period, cfg_duty, cfg_load,
    input  pwm_out, period_start, cfg_pending, failsafe, active_duty
  );

  modport slave (
    input  enable, cfg_period, cfg_duty, cfg_load,
    output pwm_out, period_start, cfg_pending, failsafe, active_duty
  );
endinterface

// File: rtl/servo_pwm_gen.sv
// Servo/ESC PWM generator: double-buffered period/duty committed on period
// boundaries, duty clamped to servo limits, watchdog-driven neutral failsafe.
module servo_pwm_gen #(
  parameter int CNT_W          = 28,
  parameter int DEFAULT_PERIOD = 1000000,
  parameter int DEFAULT_DUTY   = 75000,
  parameter int MIN_DUTY       = 50000,
  parameter int MAX_DUTY       = 100000,
  parameter int WDOG_PERIODS   = 25
) (
  input  logic             clk,
  input  logic             reset,
  servo_pwm_gen_if.slave   bus
);
  localparam int WD_W = $clog2(WDOG_PERIODS + 1);
  localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D   = CNT_W'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DUTY);
  localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DUTY);
  localparam logic [CNT_W-1:0] P_FLOOR = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG_PERIODS);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_PERIODS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_duty_q, act_duty_d;
  logic [CNT_W-1:0] shd_period_q, shd_period_d;
  logic [CNT_W-1:0] shd_duty_q, shd_duty_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             pending_q, pending_d;
  logic             failsafe_q, failsafe_d;
  logic             pwm_q, pwm_d;

  logic             running, boundary, start_commit, wdog_expire, bypass;
  logic [CNT_W-1:0] src_period, src_duty, new_period, new_duty, eff_duty;

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < P_FLOOR) ? P_FLOOR : p;
  endfunction

  // Duty is bounded by the servo limits first, then never allowed past the period.
  function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d,
                                                  input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] r;
    r = d;
    if (r < MIN_D) r = MIN_D;
    else if (r > MAX_D) r = MAX_D;
    if (r > p) r = p;
    return r;
  endfunction

  always_comb begin
    running      = bus.enable;
    boundary     = running && (cnt_q == act_period_q - ONE);
    // Pending at count 0 can only mean the counter was parked while a load arrived.
    start_commit = running && pending_q && (cnt_q == '0);
    wdog_expire  = boundary && !bus.cfg_load && (wdog_q >= WD_LAST);
    bypass       = boundary && bus.cfg_load;
    src_period   = bypass ? bus.cfg_period : shd_period_q;
    src_duty     = bypass ? bus.cfg_duty   : shd_duty_q;
    new_period   = clamp_period(src_period);
    new_duty     = clamp_duty(src_duty, new_period);
    eff_duty     = start_commit ? new_duty : act_duty_q;

    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    shd_period_d = shd_period_q;
    shd_duty_d   = shd_duty_q;
    wdog_d       = wdog_q;
    pending_d    = pending_q;
    failsafe_d   = failsafe_q;
    pwm_d        = running && (cnt_q < eff_duty);

    if (!running)      cnt_d = '0;
    else if (boundary) cnt_d = '0;
    else               cnt_d = cnt_q + ONE;

    if (bus.cfg_load) begin
      shd_period_d = bus.cfg_period;
      shd_duty_d   = bus.cfg_duty;
      pending_d    = 1'b1;
      wdog_d       = '0;
    end else if (boundary && (wdog_q != WD_MAX)) begin
      wdog_d = wdog_q + WD_W'(1);
    end

    if (wdog_expire) begin
      act_period_d = DEF_P;
      act_duty_d   = DEF_D;
      failsafe_d   = 1'b1;
      pending_d    = 1'b0;
    end else if ((boundary && (bus.cfg_load || pending_q)) || start_commit) begin
      act_period_d = new_period;
      act_duty_d   = new_duty;
      failsafe_d   = 1'b0;
      pending_d    = start_commit && bus.cfg_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      act_period_q <= DEF_P;
      act_duty_q   <= DEF_D;
      shd_period_q <= DEF_P;
      shd_duty_q   <= DEF_D;
      wdog_q       <= '0;
      pending_q    <= 1'b0;
      failsafe_q   <= 1'b0;
      pwm_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      shd_period_q <= shd_period_d;
      shd_duty_q   <= shd_duty_d;
      wdog_q       <= wdog_d;
      pending_q    <= pending_d;
      failsafe_q   <= failsafe_d;
      pwm_q        <= pwm_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = running && !reset && (cnt_q == '0);
  assign bus.cfg_pending  = pending_q;
  assign bus.failsafe     = failsafe_q;
  assign bus.active_duty  = act_duty_q;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench: stimulus queues the expected shape of each PWM period, and a
// period monitor measures length/high time/duty/failsafe and checks them.
module tb_servo_pwm_gen;
  localparam int CW = 16;

  typedef struct {
    int len;
    int high;
    int duty;
    int fs;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  servo_pwm_gen_if #(.CNT_W(CW)) bus ();

  servo_pwm_gen #(
    .CNT_W(CW), .DEFAULT_PERIOD(100), .DEFAULT_DUTY(30),
    .MIN_DUTY(20), .MAX_DUTY(60), .WDOG_PERIODS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish within limit");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_period(input int len, input int high, input int duty, input int fs);
    exp_t e;
    e.len = len; e.high = high; e.duty = duty; e.fs = fs;
    exp_q.push_back(e);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_start && n < 1000);
    if (!bus.period_start) check("period_start_timeout", 0, 1);
  endtask

  // Called at the negedge of a count-0 cycle; pulses cfg_load during count k.
  task automatic load_at(input int k, input int p, input int d);
    repeat (k) @(posedge clk);
    #1;
    bus.cfg_period = CW'(p);
    bus.cfg_duty   = CW'(d);
    bus.cfg_load   = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_load   = 1'b0;
  endtask

  // Period monitor: a period is complete when the next period_start is seen.
  initial begin
    bit   in_per;
    int   len, high, duty_s, fs_s, n_per;
    exp_t e;
    in_per = 0; len = 0; high = 0; duty_s = 0; fs_s = 0; n_per = 0;
    forever begin
      @(negedge clk);
      if (reset || !bus.enable) begin
        in_per = 0;
      end else begin
        if (in_per) begin
          len++;
          high += int'(bus.pwm_out);
          if (len == 1) begin
            duty_s = int'(bus.active_duty);
            fs_s   = int'(bus.failsafe);
          end
        end
        if (bus.period_start) begin
          if (in_per) begin
            n_per++;
            $display("period %0d: len=%0d high=%0d duty=%0d failsafe=%0d",
                     n_per, len, high, duty_s, fs_s);
            if (exp_q.size() == 0) begin
              check("unexpected_period", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("period_len", len, e.len);
              check("period_high", high, e.high);
              check("period_duty", duty_s, e.duty);
              check("period_failsafe", fs_s, e.fs);
            end
          end
          in_per = 1;
          len = 0;
          high = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_duty = '0;
    bus.cfg_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_start", int'(bus.period_start), 0);
    check("rst_pending", int'(bus.cfg_pending), 0);
    check("rst_failsafe", int'(bus.failsafe), 0);
    check("rst_duty", int'(bus.active_duty), 30);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 bus.enable = 1'b1;

    wait_start(); expect_period(100, 30, 30, 0);
    wait_start(); expect_period(100, 30, 30, 0);
    load_at(10, 50, 40);
    @(negedge clk); check("pend_set", int'(bus.cfg_pending), 1);
    repeat (88) @(negedge clk);
    check("pend_hold_at_99", int'(bus.cfg_pending), 1);
    wait_start(); check("pend_clr", int'(bus.cfg_pending), 0);
    expect_period(50, 40, 40, 0);
    load_at(5, 100, 80);
    wait_start(); expect_period(100, 60, 60, 0);
    load_at(5, 100, 10);
    wait_start(); expect_period(100, 20, 20, 0);
    load_at(5, 30, 50);
    wait_start(); expect_period(30, 30, 30, 0);
    load_at(5, 100, 30);
    wait_start(); expect_period(100, 30, 30, 0);

    load_at(99, 100, 45);
    @(negedge clk);
    check("bnd_start", int'(bus.period_start), 1);
    check("bnd_pending", int'(bus.cfg_pending), 0);
    check("bnd_duty", int'(bus.active_duty), 45);
    expect_period(100, 45, 45, 0);

    load_at(5, 100, 50);
    wait_start(); expect_period(100, 50, 50, 0);
    wait_start(); expect_period(100, 50, 50, 0);
    wait_start(); check("fs_set", int'(bus.failsafe), 1);
    expect_period(100, 30, 30, 1);
    load_at(5, 100, 40);
    @(negedge clk);
    check("fs_hold", int'(bus.failsafe), 1);
    check("fs_pending", int'(bus.cfg_pending), 1);
    wait_start(); check("fs_clr", int'(bus.failsafe), 0);
    expect_period(100, 40, 40, 0);

    wait_start();
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); check("pre_rst_pwm", int'(bus.pwm_out), 1);
    @(negedge clk);
    check("midrst_pwm", int'(bus.pwm_out), 0);
    check("midrst_start", int'(bus.period_start), 0);
    check("midrst_pending", int'(bus.cfg_pending), 0);
    check("midrst_failsafe", int'(bus.failsafe), 0);
    check("midrst_duty", int'(bus.active_duty), 30);
    @(posedge clk); #1 reset = 1'b0;

    wait_start(); expect_period(100, 30, 30, 0);
    wait_start();
    repeat (5) @(posedge clk);
    #1 bus.enable = 1'b0;
    @(negedge clk); check("trunc_pre_pwm", int'(bus.pwm_out), 1);
    @(negedge clk);
    check("dis_pwm", int'(bus.pwm_out), 0);
    check("dis_start", int'(bus.period_start), 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 bus.enable = 1'b1;
    @(negedge clk); check("restart_start", int'(bus.period_start), 1);
    expect_period(100, 30, 30, 0);

    wait_start();
    repeat (5) @(posedge clk);
    #1 bus.enable = 1'b0;
    @(posedge clk); #1;
    bus.cfg_period = CW'(60); bus.cfg_duty = CW'(25); bus.cfg_load = 1'b1;
    @(posedge clk); #1 bus.cfg_load = 1'b0;
    @(negedge clk);
    check("dis_load_pending", int'(bus.cfg_pending), 1);
    check("dis_load_duty", int'(bus.active_duty), 30);
    @(posedge clk); #1 bus.enable = 1'b1;
    @(negedge clk); check("restart2_start", int'(bus.period_start), 1);
    expect_period(60, 25, 25, 0);
    wait_start(); check("restart2_pending", int'(bus.cfg_pending), 0);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
